uart_core: RTL and testbench
============================

UART_CORE -- requirements
Module: uart_core

Interface
REQ-001 SHALL have parameter NBITS, default 8: data bits per frame, legal 5..9.
REQ-002 SHALL have parameter STPBITS, default 2: stop bits per frame, legal 1 or 2.
REQ-003 SHALL have parameter DEPTH, default 16: entries per FIFO, power of 2, 2..256.
REQ-004 SHALL have parameter DIV_W, default 16: width of the baud divisor.
REQ-005 SHALL have port clk, input, 1: the single clock; all logic on the rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have ports twr_en (in, 1) and twr_data (in, NBITS): TX FIFO write strobe and data.
REQ-008 SHALL have ports rrd_en (in, 1) and rrd_data (out, NBITS): RX FIFO read strobe and head word, first-word-fall-through.
REQ-009 SHALL have ports tx_full, tx_empty, rx_full, rx_empty (out, 1 each): FIFO status flags.
REQ-010 SHALL have ports divisor (in, DIV_W), loopback (in, 1), rxd (in, 1) and txd (out, 1): baud divisor, internal loopback select, serial input, serial output.
REQ-011 SHALL have ports rx_ovf, frame_err, parity_err (out, 1 each): one-cycle error pulses.

Function
REQ-012 SHALL generate a baud tick every divisor+1 clocks; divisor 0 ticks every clock; each bit lasts 16 ticks; a new divisor takes effect at the next counter reload.
REQ-013 SHALL ignore a TX write when tx_full and an RX read when rx_empty; neither alters FIFO state.
REQ-014 SHALL, on a simultaneous read and write to a full FIFO, perform both with count unchanged; on an empty FIFO, perform the write only.
REQ-015 SHALL use pointer wrap-around modulo DEPTH with a count of width log2(DEPTH)+1.
REQ-016 SHALL use a TX FSM with states IDLE, START, DATA, PARITY, STOP; IDLE drives txd=1.
REQ-017 SHALL pop the TX FIFO when in IDLE and !tx_empty, and drive the start bit (0) within 2 clocks of the pop.
REQ-018 SHALL send data LSB first, NBITS bits, then PARITY if compiled in, then STPBITS x 16 ticks of 1, then return to IDLE; back-to-back words have no extra idle gap.
REQ-019 SHALL pass rxd through a 2-flop synchronizer; when loopback=1, the RX path SHALL take the internal txd instead, and external txd SHALL still be driven.
REQ-020 SHALL use an RX FSM with states IDLE, START, DATA, PARITY, STOP; IDLE leaves on a 1->0 edge of the selected input.
REQ-021 SHALL sample the start bit at tick 7; if it reads 1, the FSM returns to IDLE (glitch rejection) and nothing is written.
REQ-022 SHALL sample each data/parity bit at tick 7 of its bit and the first stop bit at tick 7.
REQ-023 SHALL, on stop bit = 0, pulse frame_err for one clock, discard the word, and return to IDLE.
REQ-024 SHALL write a good word to the RX FIFO one clock after the stop-bit sample; if rx_full, it SHALL drop the word and pulse rx_ovf.
REQ-025 SHALL ignore RX stop bits beyond the first.

Reset
REQ-026 SHALL, while reset=0 (asynchronously), empty both FIFOs and put both FSMs in IDLE, clear the baud counter, and set txd=1, tx_empty=1, rx_empty=1, tx_full=0, rx_full=0, rx_ovf=0, frame_err=0, parity_err=0, rrd_data=0.
REQ-027 SHALL abort any frame in progress on reset, with no partial word delivered.
REQ-028 SHALL resume operation on the first clk edge after reset deasserts.

Configuration
REQ-029 SHALL, with UART_PARITY_EN defined, send and check an even-parity bit after the data bits; on a mismatch it SHALL pulse parity_err and discard the word.
REQ-030 SHALL, without UART_PARITY_EN, omit the PARITY state and frame bit and tie parity_err to 0.

Verification
REQ-031 SHALL cover: NBITS=8, STPBITS=1, divisor=0, loopback=1, write 0xA5 -> txd low for 16 clk, then 1,0,1,0,0,1,0,1 of 16 clk each, then high; rx_empty falls and rrd_data=0xA5.
REQ-032 SHALL cover: DEPTH=4, five writes with no drain -> tx_full after the 4th write (while the FSM is stalled by reset-held divisor), 5th write ignored; the four words are received in order.
REQ-033 SHALL cover: a 3-clock low glitch on rxd with divisor=3 -> no RX write and no error pulse.
REQ-034 SHALL cover: a frame with stop bit forced to 0 -> frame_err pulses once and rx_empty stays 1.
REQ-035 SHALL cover: RX FIFO full (4 words unread) plus one more frame -> rx_ovf pulses once and the contents are unchanged.
REQ-036 SHALL cover: reset asserted mid-DATA -> txd=1 immediately and both FIFOs empty; with UART_PARITY_EN, a frame carrying a flipped parity bit -> parity_err pulses.

Source files
------------

// File: rtl/uart_core.sv
// UART core: baud generator, TX/RX FIFOs (first-word-fall-through) and
// TX/RX frame state machines with internal loopback.
// Optional feature macro: UART_PARITY_EN adds an even-parity bit after the
// data bits on transmit and checks it on receive.

// Synchronous FIFO with occupancy count; head word is visible while not empty
module uart_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         wr_en,
   input  logic [W-1:0] wr_data,
   input  logic         rd_en,
   output logic [W-1:0] rd_data,
   output logic         full,
   output logic         empty
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          rd_ok;
   logic          wr_ok;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign rd_ok   = rd_en && !empty;
   assign wr_ok   = wr_en && (!full || rd_ok);
   assign rd_data = empty ? '0 : mem[rd_ptr];

   // Pointers wrap naturally modulo DEPTH; count tracks occupancy
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
         if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_ok, rd_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage array needs no reset; the read port masks it to 0 while empty
   always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_ptr] <= wr_data;
   end
endmodule

module uart_core #(
   parameter int NBITS   = 8,
   parameter int STPBITS = 2,
   parameter int DEPTH   = 16,
   parameter int DIV_W   = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             twr_en,
   input  logic [NBITS-1:0] twr_data,
   input  logic             rrd_en,
   output logic [NBITS-1:0] rrd_data,
   output logic             tx_full,
   output logic             tx_empty,
   output logic             rx_full,
   output logic             rx_empty,
   input  logic [DIV_W-1:0] divisor,
   input  logic             loopback,
   input  logic             rxd,
   output logic             txd,
   output logic             rx_ovf,
   output logic             frame_err,
   output logic             parity_err
);
   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;

   localparam logic [3:0] LAST_BIT  = 4'(NBITS-1);
   localparam logic       LAST_STOP = 1'(STPBITS-1);

   logic [DIV_W-1:0] baud_cnt;
   logic             tick;

   logic [NBITS-1:0] tx_head;
   logic             tx_pop;
   state_t           tx_state;
   logic [3:0]       tx_tick_cnt;
   logic [3:0]       tx_bit_cnt;
   logic             tx_stop_cnt;
   logic [NBITS-1:0] tx_shift;
   logic             tx_bit_end;

   logic             rx_sync1;
   logic             rx_sync2;
   logic             rx_in;
   logic             rx_prev;
   state_t           rx_state;
   logic [3:0]       rx_tick_cnt;
   logic [3:0]       rx_bit_cnt;
   logic [NBITS-1:0] rx_shift;
   logic             rx_wr_req;
   logic             rx_mid;
   logic             rx_end;

`ifdef UART_PARITY_EN
   logic             tx_par;
   logic             rx_par_bit;
`endif

   assign tick = (baud_cnt == '0);

   // Baud counter reloads from divisor on each tick, so a new divisor lands at reload
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) baud_cnt <= '0;
      else if (tick) baud_cnt <= divisor;
      else baud_cnt <= baud_cnt - 1'b1;
   end

   uart_fifo #(.W(NBITS), .DEPTH(DEPTH)) u_tx_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (twr_en),
      .wr_data (twr_data),
      .rd_en   (tx_pop),
      .rd_data (tx_head),
      .full    (tx_full),
      .empty   (tx_empty)
   );

   // Pops happen on a baud tick, either from IDLE or at the end of the last
   // stop bit so consecutive words go out with no idle gap
   assign tx_bit_end = tick && (tx_tick_cnt == 4'd15);
   assign tx_pop     = !tx_empty && tick &&
                       ((tx_state == IDLE) ||
                        (tx_state == STOP && tx_bit_end && tx_stop_cnt == LAST_STOP));

   // Transmit frame sequencer; the 4-bit tick counter wraps once per bit
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx_state    <= IDLE;
         txd         <= 1'b1;
         tx_tick_cnt <= '0;
         tx_bit_cnt  <= '0;
         tx_stop_cnt <= 1'b0;
         tx_shift    <= '0;
`ifdef UART_PARITY_EN
         tx_par      <= 1'b0;
`endif
      end else begin
         if (tick) tx_tick_cnt <= tx_tick_cnt + 1'b1;
         case (tx_state)
            IDLE: begin
               txd <= 1'b1;
               if (tx_pop) begin
                  tx_shift    <= tx_head;
`ifdef UART_PARITY_EN
                  tx_par      <= ^tx_head;
`endif
                  tx_tick_cnt <= '0;
                  txd         <= 1'b0;
                  tx_state    <= START;
               end
            end
            START: begin
               if (tx_bit_end) begin
                  tx_bit_cnt <= '0;
                  txd        <= tx_shift[0];
                  tx_state   <= DATA;
               end
            end
            DATA: begin
               if (tx_bit_end) begin
                  if (tx_bit_cnt == LAST_BIT) begin
`ifdef UART_PARITY_EN
                     txd         <= tx_par;
                     tx_state    <= PARITY;
`else
                     txd         <= 1'b1;
                     tx_stop_cnt <= 1'b0;
                     tx_state    <= STOP;
`endif
                  end else begin
                     tx_bit_cnt <= tx_bit_cnt + 1'b1;
                     txd        <= tx_shift[1];
                     tx_shift   <= {1'b0, tx_shift[NBITS-1:1]};
                  end
               end
            end
`ifdef UART_PARITY_EN
            PARITY: begin
               if (tx_bit_end) begin
                  txd         <= 1'b1;
                  tx_stop_cnt <= 1'b0;
                  tx_state    <= STOP;
               end
            end
`endif
            STOP: begin
               if (tx_bit_end) begin
                  if (tx_stop_cnt == LAST_STOP) begin
                     if (tx_pop) begin
                        tx_shift <= tx_head;
`ifdef UART_PARITY_EN
                        tx_par   <= ^tx_head;
`endif
                        txd      <= 1'b0;
                        tx_state <= START;
                     end else begin
                        txd      <= 1'b1;
                        tx_state <= IDLE;
                     end
                  end else begin
                     tx_stop_cnt <= tx_stop_cnt + 1'b1;
                  end
               end
            end
            default: begin
               txd      <= 1'b1;
               tx_state <= IDLE;
            end
         endcase
      end
   end

   // Two-flop synchronizer on the external line plus previous-value for edge detect
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_sync1 <= 1'b1;
         rx_sync2 <= 1'b1;
         rx_prev  <= 1'b1;
      end else begin
         rx_sync1 <= rxd;
         rx_sync2 <= rx_sync1;
         rx_prev  <= rx_in;
      end
   end

   assign rx_in  = loopback ? txd : rx_sync2;
   assign rx_mid = tick && (rx_tick_cnt == 4'd7);
   assign rx_end = tick && (rx_tick_cnt == 4'd15);

   // Receive frame sequencer; samples mid-bit and requests a FIFO write after a good stop bit
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_state    <= IDLE;
         rx_tick_cnt <= '0;
         rx_bit_cnt  <= '0;
         rx_shift    <= '0;
         rx_wr_req   <= 1'b0;
         frame_err   <= 1'b0;
`ifdef UART_PARITY_EN
         rx_par_bit  <= 1'b0;
         parity_err  <= 1'b0;
`endif
      end else begin
         rx_wr_req <= 1'b0;
         frame_err <= 1'b0;
`ifdef UART_PARITY_EN
         parity_err <= 1'b0;
`endif
         if (tick) rx_tick_cnt <= rx_tick_cnt + 1'b1;
         case (rx_state)
            IDLE: begin
               if (rx_prev && !rx_in) begin
                  rx_tick_cnt <= '0;
                  rx_state    <= START;
               end
            end
            START: begin
               if (rx_mid && rx_in) begin
                  rx_state <= IDLE;
               end else if (rx_end) begin
                  rx_bit_cnt <= '0;
                  rx_state   <= DATA;
               end
            end
            DATA: begin
               if (rx_mid) rx_shift <= {rx_in, rx_shift[NBITS-1:1]};
               if (rx_end) begin
                  if (rx_bit_cnt == LAST_BIT) begin
`ifdef UART_PARITY_EN
                     rx_state <= PARITY;
`else
                     rx_state <= STOP;
`endif
                  end else begin
                     rx_bit_cnt <= rx_bit_cnt + 1'b1;
                  end
               end
            end
`ifdef UART_PARITY_EN
            PARITY: begin
               if (rx_mid) rx_par_bit <= rx_in;
               if (rx_end) rx_state <= STOP;
            end
`endif
            STOP: begin
               if (rx_mid) begin
                  rx_state <= IDLE;
                  if (!rx_in) begin
                     frame_err <= 1'b1;
`ifdef UART_PARITY_EN
                  end else if (rx_par_bit != ^rx_shift) begin
                     parity_err <= 1'b1;
`endif
                  end else begin
                     rx_wr_req <= 1'b1;
                  end
               end
            end
            default: rx_state <= IDLE;
         endcase
      end
   end

`ifndef UART_PARITY_EN
   assign parity_err = 1'b0;
`endif

   uart_fifo #(.W(NBITS), .DEPTH(DEPTH)) u_rx_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (rx_wr_req),
      .wr_data (rx_shift),
      .rd_en   (rrd_en),
      .rd_data (rrd_data),
      .full    (rx_full),
      .empty   (rx_empty)
   );

   // Overrun pulse when a received word meets a full FIFO with no read to make room
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) rx_ovf <= 1'b0;
      else rx_ovf <= rx_wr_req && rx_full && !rrd_en;
   end
endmodule

// File: tb/tb_uart_core.sv
// Directed self-checking bench for uart_core (NBITS=8, STPBITS=1, DEPTH=4).
// Builds with or without UART_PARITY_EN.
module tb_uart_core;
   logic        clk;
   logic        reset;
   logic        twr_en;
   logic [7:0]  twr_data;
   logic        rrd_en;
   logic [7:0]  rrd_data;
   logic        tx_full;
   logic        tx_empty;
   logic        rx_full;
   logic        rx_empty;
   logic [15:0] divisor;
   logic        loopback;
   logic        rxd;
   logic        txd;
   logic        rx_ovf;
   logic        frame_err;
   logic        parity_err;

   int checks = 0;
   int errors = 0;
   int frame_err_cnt = 0;
   int parity_err_cnt = 0;
   int rx_ovf_cnt = 0;

   uart_core #(.NBITS(8), .STPBITS(1), .DEPTH(4), .DIV_W(16)) dut (
      .clk        (clk),
      .reset      (reset),
      .twr_en     (twr_en),
      .twr_data   (twr_data),
      .rrd_en     (rrd_en),
      .rrd_data   (rrd_data),
      .tx_full    (tx_full),
      .tx_empty   (tx_empty),
      .rx_full    (rx_full),
      .rx_empty   (rx_empty),
      .divisor    (divisor),
      .loopback   (loopback),
      .rxd        (rxd),
      .txd        (txd),
      .rx_ovf     (rx_ovf),
      .frame_err  (frame_err),
      .parity_err (parity_err)
   );

   // Free-running 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Tally error pulses cycle by cycle, away from the active edge
   always @(negedge clk) begin
      if (frame_err === 1'b1) frame_err_cnt++;
      if (parity_err === 1'b1) parity_err_cnt++;
      if (rx_ovf === 1'b1) rx_ovf_cnt++;
   end

   // Hard stop if something hangs
   initial begin
      #900000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Drive one frame on rxd at 16 clocks per bit (divisor 0), then idle
   task automatic applyStimulus(input logic [7:0] data, input logic stop_val,
                                input logic flip);
      rxd = 1'b0;
      repeat (16) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rxd = data[i];
         repeat (16) @(negedge clk);
      end
`ifdef UART_PARITY_EN
      rxd = (^data) ^ flip;
      repeat (16) @(negedge clk);
`else
      if (flip) $display("[TB] parity flip requested in a build without parity");
`endif
      rxd = stop_val;
      repeat (16) @(negedge clk);
      rxd = 1'b1;
      repeat (20) @(negedge clk);
   endtask

   task automatic readWord();
      rrd_en = 1'b1;
      @(negedge clk);
      rrd_en = 1'b0;
   endtask

   initial begin
      int n;
      int base_fe;
      int base_pe;
      int base_ovf;
      logic [7:0] pat;
      logic [7:0] exp_words [4];

      reset    = 1'b0;
      twr_en   = 1'b0;
      twr_data = 8'h00;
      rrd_en   = 1'b0;
      divisor  = 16'd0;
      loopback = 1'b1;
      rxd      = 1'b1;
      repeat (3) @(negedge clk);

      $display("[TB] reset state");
      checkOutput("rst_txd", txd, 1);
      checkOutput("rst_tx_empty", tx_empty, 1);
      checkOutput("rst_rx_empty", rx_empty, 1);
      checkOutput("rst_tx_full", tx_full, 0);
      checkOutput("rst_rx_full", rx_full, 0);
      checkOutput("rst_errs", {rx_ovf, frame_err, parity_err}, 0);
      checkOutput("rst_rrd_data", rrd_data, 0);
      reset = 1'b1;
      repeat (3) @(negedge clk);

      $display("[TB] loopback frame 0xA5");
      pat = 8'hA5;
      twr_data = 8'hA5;
      twr_en = 1'b1;
      @(negedge clk);
      twr_en = 1'b0;
      n = 0;
      while (txd !== 1'b0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      checkOutput("tx_start_seen", txd, 0);
      repeat (8) @(negedge clk);
      checkOutput("tx_start_mid", txd, 0);
      repeat (7) @(negedge clk);
      checkOutput("tx_start_last_clk", txd, 0);
      @(negedge clk);
      checkOutput("tx_bit0_first_clk", txd, 1);
      repeat (8) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         checkOutput($sformatf("tx_bit%0d", i), txd, pat[i]);
         repeat (16) @(negedge clk);
      end
`ifdef UART_PARITY_EN
      checkOutput("tx_parity", txd, 0);
      repeat (16) @(negedge clk);
`endif
      checkOutput("tx_stop", txd, 1);
      n = 0;
      while (rx_empty !== 1'b0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      checkOutput("lb_rx_empty", rx_empty, 0);
      checkOutput("lb_rrd_data", rrd_data, 8'hA5);
      readWord();
      checkOutput("lb_rx_empty_after_read", rx_empty, 1);
      checkOutput("lb_txd_idle", txd, 1);

      $display("[TB] external good frame 0x3A");
      loopback = 1'b0;
      repeat (4) @(negedge clk);
      applyStimulus(8'h3A, 1'b1, 1'b0);
      checkOutput("ext_rx_empty", rx_empty, 0);
      checkOutput("ext_rrd_data", rrd_data, 8'h3A);
      readWord();

      $display("[TB] 3-clock glitch at divisor 3");
      base_fe = frame_err_cnt;
      base_pe = parity_err_cnt;
      divisor = 16'd3;
      repeat (10) @(negedge clk);
      rxd = 1'b0;
      repeat (3) @(negedge clk);
      rxd = 1'b1;
      repeat (200) @(negedge clk);
      checkOutput("glitch_rx_empty", rx_empty, 1);
      checkOutput("glitch_frame_err", frame_err_cnt - base_fe, 0);
      checkOutput("glitch_parity_err", parity_err_cnt - base_pe, 0);
      divisor = 16'd0;
      repeat (10) @(negedge clk);

      $display("[TB] frame with stop bit 0");
      base_fe = frame_err_cnt;
      applyStimulus(8'h96, 1'b0, 1'b0);
      checkOutput("ferr_pulses", frame_err_cnt - base_fe, 1);
      checkOutput("ferr_rx_empty", rx_empty, 1);

`ifdef UART_PARITY_EN
      $display("[TB] frame with flipped parity");
      base_pe = parity_err_cnt;
      applyStimulus(8'h0F, 1'b1, 1'b1);
      checkOutput("perr_pulses", parity_err_cnt - base_pe, 1);
      checkOutput("perr_rx_empty", rx_empty, 1);
`endif

      $display("[TB] TX FIFO fill while stalled by divisor 255");
      loopback = 1'b1;
      divisor = 16'd255;
      reset = 1'b0;
      repeat (3) @(negedge clk);
      exp_words[0] = 8'h11;
      exp_words[1] = 8'h22;
      exp_words[2] = 8'h33;
      exp_words[3] = 8'h44;
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         twr_en = 1'b1;
         twr_data = exp_words[i];
         @(negedge clk);
      end
      twr_en = 1'b0;
      checkOutput("fill_tx_full_4", tx_full, 1);
      checkOutput("fill_txd_idle", txd, 1);
      twr_en = 1'b1;
      twr_data = 8'h55;
      @(negedge clk);
      twr_en = 1'b0;
      checkOutput("fill_tx_full_5", tx_full, 1);
      divisor = 16'd0;
      n = 0;
      while (rx_full !== 1'b1 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      checkOutput("fill_rx_full", rx_full, 1);
      base_ovf = rx_ovf_cnt;
      repeat (400) @(negedge clk);
      checkOutput("fill_no_ovf", rx_ovf_cnt - base_ovf, 0);
      checkOutput("fill_tx_empty", tx_empty, 1);

      $display("[TB] overrun on full RX FIFO");
      twr_data = 8'h3C;
      twr_en = 1'b1;
      @(negedge clk);
      twr_en = 1'b0;
      n = 0;
      while (rx_ovf_cnt == base_ovf && n < 400) begin
         @(negedge clk);
         n++;
      end
      repeat (20) @(negedge clk);
      checkOutput("ovf_pulses", rx_ovf_cnt - base_ovf, 1);
      checkOutput("ovf_rx_full", rx_full, 1);
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("ovf_word%0d", i), rrd_data, exp_words[i]);
         readWord();
      end
      checkOutput("ovf_rx_empty", rx_empty, 1);

      $display("[TB] reset mid-DATA");
      twr_data = 8'h5A;
      twr_en = 1'b1;
      @(negedge clk);
      twr_en = 1'b0;
      n = 0;
      while (rx_empty !== 1'b0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      checkOutput("mid_preload_rx", rx_empty, 0);
      repeat (20) @(negedge clk);
      twr_data = 8'h00;
      twr_en = 1'b1;
      @(negedge clk);
      twr_data = 8'hFF;
      @(negedge clk);
      twr_en = 1'b0;
      n = 0;
      while (txd !== 1'b0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      repeat (40) @(negedge clk);
      checkOutput("mid_txd_low", txd, 0);
      checkOutput("mid_tx_pending", tx_empty, 0);
      #2;
      reset = 1'b0;
      #1;
      checkOutput("mid_rst_txd", txd, 1);
      checkOutput("mid_rst_tx_empty", tx_empty, 1);
      checkOutput("mid_rst_rx_empty", rx_empty, 1);
      checkOutput("mid_rst_full", {tx_full, rx_full}, 0);
      checkOutput("mid_rst_rrd_data", rrd_data, 0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (400) @(negedge clk);
      checkOutput("mid_post_rx_empty", rx_empty, 1);
      checkOutput("mid_post_txd", txd, 1);
      checkOutput("mid_post_tx_empty", tx_empty, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
